// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider, signed or unsigned, restoring radix-2 (one quotient bit per cycle).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed division, 0 = unsigned
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request, held high until ready_o is seen
//   annul_i      aborts an operation that is still iterating
//   result_o     {remainder, quotient}, registered
//   ready_o      result_o valid, registered
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] wreg_q, wreg_d;
  logic [31:0] divisor_q, divisor_d;
  logic        sgn_q, sgn_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] res_q, res_d;
  logic [63:0] result_d;
  logic        ready_d;

  logic [32:0] trial;
  logic [64:0] step;
  logic [31:0] quo, rem;
  logic [31:0] op1_abs, op2_abs;

  always_comb begin
    // Working register: [64:33] partial remainder, low bits shift dividend out / quotient in.
    trial   = {1'b0, wreg_q[63:32]} - {1'b0, divisor_q};
    step    = trial[32] ? {wreg_q[63:0], 1'b0} : {trial[31:0], wreg_q[31:0], 1'b1};
    quo     = (sgn_q && (neg1_q ^ neg2_q)) ? (~step[31:0] + 32'd1) : step[31:0];
    rem     = (sgn_q && neg1_q) ? (~step[64:33] + 32'd1) : step[64:33];
    op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    state_d   = state_q;
    cnt_d     = cnt_q;
    wreg_d    = wreg_q;
    divisor_d = divisor_q;
    sgn_d     = sgn_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    res_d     = res_q;
    result_d  = 64'd0;
    ready_d   = 1'b0;

    unique case (state_q)
      StFree: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = StByZero;
          end else begin
            state_d   = StOn;
            cnt_d     = 6'd0;
            wreg_d    = {32'd0, op1_abs, 1'b0};
            divisor_d = op2_abs;
            sgn_d     = signed_div_i;
            neg1_d    = opdata1_i[31];
            neg2_d    = opdata2_i[31];
          end
        end
      end
      StByZero: begin
        res_d   = 64'd0;
        state_d = StEnd;
      end
      StOn: begin
        if (annul_i) begin
          state_d = StFree;
        end else begin
          wreg_d = step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = StEnd;
            res_d   = {rem, quo};
          end
        end
      end
      StEnd: begin
        if (start_i) begin
          ready_d  = 1'b1;
          result_d = res_q;
        end else begin
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= 6'd0;
      wreg_q    <= 65'd0;
      divisor_q <= 32'd0;
      sgn_q     <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      res_q     <= 64'd0;
      result_o  <= 64'd0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wreg_q    <= wreg_d;
      divisor_q <= divisor_d;
      sgn_q     <= sgn_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      res_q     <= res_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The port clk SHALL be an input, 1 bit wide, and act as the rising-edge clock.
REQ-003 The port rst SHALL be an input, 1 bit wide, and act as the synchronous, active-high reset.
REQ-004 The port signed_div_i SHALL be an input, 1 bit wide; 1 selects signed division and 0 selects unsigned.
REQ-005 The port opdata1_i SHALL be an input, 32 bits wide, carrying the dividend.
REQ-006 The port opdata2_i SHALL be an input, 32 bits wide, carrying the divisor.
REQ-007 The port start_i SHALL be an input, 1 bit wide; the requester holds it at 1 until ready_o is seen, then drops it.
REQ-008 The port annul_i SHALL be an input, 1 bit wide; 1 aborts an operation in progress.
REQ-009 The port result_o SHALL be an output, 64 bits wide, formatted as {remainder[63:32], quotient[31:0]}.
REQ-010 The port ready_o SHALL be an output, 1 bit wide; 1 means result_o is valid.

Function
REQ-011 The block SHALL use four states: FREE, BYZERO, ON and END.
REQ-012 In FREE, if start_i=1, annul_i=0 and opdata2_i=0, the block SHALL go to BYZERO.
REQ-013 In FREE, if start_i=1, annul_i=0 and opdata2_i!=0, the block SHALL go to ON, load the iteration counter with 0 and capture the operands.
REQ-014 In FREE, in every other case, the block SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-015 At capture with signed_div_i=1, the block SHALL convert each negative operand to its two's-complement magnitude; with signed_div_i=0, it SHALL use the operands unchanged.
REQ-016 The block SHALL latch signed_div_i and both operand sign bits at capture; input changes after capture SHALL NOT affect the operation.
REQ-017 In BYZERO, the block SHALL set the stored result to 0 and go to END on the next edge.
REQ-018 In ON, the block SHALL run restoring radix-2 division, one quotient bit per cycle, on a 65-bit working register.
REQ-019 Each ON step SHALL compute a 33-bit trial subtract of the partial remainder minus the divisor.
REQ-020 On a non-negative trial result, the step SHALL shift in quotient bit 1 and keep the difference; otherwise it SHALL shift in 0 and keep the shifted partial remainder.
REQ-021 The counter SHALL increment once per ON cycle; after exactly 32 ON cycles (counter value 31 consumed), the block SHALL go to END.
REQ-022 Entering END from ON, the block SHALL apply the latched signs: negate the quotient when the operand signs differed (signed only), and negate the remainder when the dividend was negative (signed only).
REQ-023 The block SHALL store the signed-corrected result into result_o.
REQ-024 In ON, annul_i=1 SHALL send the block to FREE on the next edge, discarding the operation; ready_o SHALL stay 0.
REQ-025 In END, the block SHALL drive ready_o=1 and hold result_o stable.
REQ-026 The block SHALL stay in END while start_i=1.
REQ-027 When start_i=0 is sampled in END, the block SHALL go to FREE, with ready_o=0 and result_o=0 from the next cycle.
REQ-028 Latency, counting from the edge k that samples start_i=1 in FREE, SHALL be ready_o=1 after edge k+33 for a non-zero divisor and after edge k+2 for a zero divisor.
REQ-029 Overflow 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0, with no exception and no extra cycles.
REQ-030 A dividend of 0 SHALL give result 0 after the full 33-cycle latency.
REQ-031 annul_i SHALL have no effect in END or BYZERO.
REQ-032 ready_o and result_o SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-033 rst=1 at any edge SHALL force state FREE, counter 0, working register 0, result_o=0 and ready_o=0 from the next cycle.
REQ-034 rst=1 mid-operation SHALL abort the operation; after rst falls, a new start SHALL behave as from power-up.

Verification
REQ-035 Unsigned 100/7 (0x64 / 0x7), start held -> ready_o=1 after edge k+33 with result_o=0x00000002_0000000E.
REQ-036 Signed -7/2 (0xFFFFFFF9 / 0x2) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> result_o=0x00000001_FFFFFFFD.
REQ-037 Divisor 0 (e.g. 0x1234 / 0) -> ready_o=1 after edge k+2 with result_o=0; start held 5 more cycles -> ready_o stays 1; start dropped -> ready_o=0 next cycle.
REQ-038 annul_i pulsed at ON iteration 10 -> block returns to FREE and ready_o never rises; a following unsigned 0xFFFFFFFF/0x10 -> result_o=0x0000000F_0FFFFFFF at k+33.
REQ-039 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000; rst asserted at iteration 20 of another operation -> ready_o=0 and result_o=0 next cycle, and FREE on restart.
